// File: rtl/enc_pkg.sv
// Shared widths and event payload for the encoder capture path and the packetiser.
package enc_pkg;

  localparam int unsigned TS_W   = 64;
  localparam int unsigned EVT_W  = TS_W + 1;
  localparam int unsigned DROP_W = 32;

  // One timestamped transition: counter value and the level after the edge.
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic            state;
  } enc_evt_t;

endpackage

// File: rtl/enc_evt_fifo.sv
// Generic synchronous first-word-fall-through FIFO with wrap-bit pointers.
module enc_evt_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  output logic                    full,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push then.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all queued entries.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are only visible through dout while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/enc_edge_capture.sv
// Timestamps filtered encoder-line transitions and queues them as AXI4-Stream events.
module enc_edge_capture
  import enc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           enc_in,
  input  logic                           enable,
  input  logic                           clr_ovf,
  output logic [TS_W-1:0]                m_axis_tdata,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           ovf_sticky,
  output logic [DROP_W-1:0]              drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

  logic [TS_W-1:0]        ts_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syn;
  logic                   filt;
  logic [FCNT_W-1:0]      fcnt;
  logic                   fire_c;
  logic                   evt_vld;
  enc_evt_t               evt_q;
  enc_evt_t               fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   push;
  logic                   drop;

  assign syn    = sync_q[SYNC_STAGES-1];
  assign fire_c = (syn != filt) && (fcnt == FCNT_LAST);

  // Free-running timestamp counter, wraps silently.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + TS_W'(1);
  end

  // Metastability synchroniser for the asynchronous encoder line.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], enc_in};
  end

  // Debounce: accept a new level after FILT_LEN consecutive differing cycles.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (syn == filt) begin
      fcnt <= '0;
    end else if (fcnt == FCNT_LAST) begin
      filt <= syn;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FCNT_W'(1);
    end
  end

  // Capture the event with the counter value of the accepting cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      evt_vld <= 1'b0;
      evt_q   <= '0;
    end else begin
      evt_vld <= fire_c;
      if (fire_c) evt_q <= '{ts: ts_cnt, state: syn};
    end
  end

  assign pop  = m_axis_tvalid & m_axis_tready;
  assign push = evt_vld & enable;
  assign drop = push & fifo_full & ~pop;

  // Overflow statistics; a clear in the same cycle as a drop still counts that drop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (clr_ovf) begin
      ovf_sticky <= drop;
      drop_cnt   <= DROP_W'(drop);
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  enc_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push    (push),
    .din     (evt_q),
    .full    (fifo_full),
    .pop     (pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_dout.ts;
  assign m_axis_tuser  = fifo_dout.state;
  assign m_axis_tlast  = 1'b1;

endmodule

// File: tb/tb_enc_edge_capture.sv
// Scoreboard bench for enc_edge_capture (SYNC_STAGES=2, FILT_LEN=4, FIFO_DEPTH=16).
module tb_enc_edge_capture;
  import enc_pkg::*;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              enc_in = 1'b0;
  logic              enable = 1'b1;
  logic              clr_ovf = 1'b0;
  logic              m_axis_tready = 1'b1;
  logic [TS_W-1:0]   m_axis_tdata;
  logic              m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              ovf_sticky;
  logic [DROP_W-1:0] drop_cnt;
  logic [4:0]        fifo_level;

  // mode 0: absolute ts; mode 1: ts near the top of the range; mode 2: ts delta from previous event
  typedef struct {
    logic [63:0] ts;
    logic        state;
    int          mode;
  } sb_t;

  sb_t         sb_q[$];
  logic [63:0] cyc;
  logic [63:0] last_ts = '0;
  logic        enc_lvl = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  enc_edge_capture #(
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .enc_in        (enc_in),
    .enable        (enable),
    .clr_ovf       (clr_ovf),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .ovf_sticky    (ovf_sticky),
    .drop_cnt      (drop_cnt),
    .fifo_level    (fifo_level)
  );

  // Reference cycle count since reset release.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) cyc <= '0;
    else          cyc <= cyc + 64'd1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Flip the encoder line; the event is sampled at the next edge and timestamped 4 cycles later.
  task automatic toggle(input bit store, input int mode, input logic [63:0] ts_arg);
    enc_lvl = ~enc_lvl;
    enc_in  = enc_lvl;
    if (store) begin
      if (mode == 0) sb_q.push_back('{ts: cyc + 64'd5, state: enc_lvl, mode: 0});
      else           sb_q.push_back('{ts: ts_arg, state: enc_lvl, mode: mode});
    end
  endtask

  // Pops the scoreboard on every accepted beat.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_evt", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          case (e.mode)
            0:       check_eq("evt_ts", m_axis_tdata, e.ts);
            1:       check_eq("evt_ts_top", 64'(m_axis_tdata >= 64'hFFFF_FFFF_FFFF_FFF0), 64'd1);
            default: check_eq("evt_ts_delta", m_axis_tdata - last_ts, e.ts);
          endcase
          check_eq("evt_state", 64'(m_axis_tuser), 64'(e.state));
          check_eq("evt_tlast", 64'(m_axis_tlast), 64'd1);
        end
        last_ts = m_axis_tdata;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    aresetn = 1'b1;
    #1;
    check_eq("rst_tdata", m_axis_tdata, 64'd0);
    check_eq("rst_tuser", 64'(m_axis_tuser), 64'd0);
    check_eq("rst_level", 64'(fifo_level), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("rst_ovf", 64'(ovf_sticky), 64'd0);

    // 1. Clean edges: sampled at edges 100 and 200
    while (cyc != 64'd99) tick();
    toggle(1'b1, 0, '0);
    while (cyc != 64'd105) tick();
    @(negedge clk);
    check_eq("t1_tvalid_105", 64'(m_axis_tvalid), 64'd0);
    tick();
    @(negedge clk);
    check_eq("t1_tvalid_106", 64'(m_axis_tvalid), 64'd1);
    while (cyc != 64'd199) tick();
    toggle(1'b1, 0, '0);
    wait_cycles(20);
    check_eq("t1_sb_empty", 64'(sb_q.size()), 64'd0);

    // 2. Glitch of 3 synced cycles is rejected; 4 cycles is accepted
    wait_cycles(50);
    toggle(1'b0, 0, '0);
    wait_cycles(3);
    toggle(1'b0, 0, '0);
    wait_cycles(20);
    check_eq("t2_glitch_level", 64'(fifo_level), 64'd0);
    check_eq("t2_glitch_tvalid", 64'(m_axis_tvalid), 64'd0);
    toggle(1'b1, 0, '0);
    wait_cycles(4);
    toggle(1'b1, 0, '0);
    wait_cycles(20);
    check_eq("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // 3. Back-pressure with overflow, then drain and clear
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      toggle(i < 16, 0, '0);
      wait_cycles(10);
    end
    wait_cycles(10);
    check_eq("t3_level", 64'(fifo_level), 64'd16);
    check_eq("t3_drop", 64'(drop_cnt), 64'd4);
    check_eq("t3_ovf", 64'(ovf_sticky), 64'd1);
    check_eq("t3_tlast", 64'(m_axis_tlast), 64'd1);
    m_axis_tready = 1'b1;
    wait_cycles(30);
    check_eq("t3_sb_empty", 64'(sb_q.size()), 64'd0);
    check_eq("t3_level_drained", 64'(fifo_level), 64'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("t3_clr_drop", 64'(drop_cnt), 64'd0);
    check_eq("t3_clr_ovf", 64'(ovf_sticky), 64'd0);

    // 4. Full FIFO with a pop in the same cycle as a push
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      toggle(1'b1, 0, '0);
      wait_cycles(10);
    end
    check_eq("t4_level_pre", 64'(fifo_level), 64'd16);
    toggle(1'b1, 0, '0);
    wait_cycles(6);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check_eq("t4_level_full", 64'(fifo_level), 64'd16);
    check_eq("t4_drop", 64'(drop_cnt), 64'd0);
    check_eq("t4_ovf", 64'(ovf_sticky), 64'd0);
    m_axis_tready = 1'b1;
    wait_cycles(30);
    check_eq("t4_sb_empty", 64'(sb_q.size()), 64'd0);

    // 5. Disabled capture, then asynchronous reset with queued events
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle(1'b0, 0, '0);
      wait_cycles(10);
    end
    wait_cycles(10);
    check_eq("t5_dis_level", 64'(fifo_level), 64'd0);
    check_eq("t5_dis_drop", 64'(drop_cnt), 64'd0);
    check_eq("t5_dis_tvalid", 64'(m_axis_tvalid), 64'd0);
    enable = 1'b1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      toggle(1'b0, 0, '0);
      wait_cycles(10);
    end
    check_eq("t5_level_queued", 64'(fifo_level), 64'd5);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("t5_async_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("t5_async_level", 64'(fifo_level), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    // A high line at release yields a rising event; the counter restarts from 0.
    if (enc_lvl) sb_q.push_back('{ts: cyc + 64'd5, state: 1'b1, mode: 0});
    wait_cycles(20);
    toggle(1'b1, 0, '0);
    wait_cycles(20);
    check_eq("t5_sb_empty", 64'(sb_q.size()), 64'd0);

    // 6. Counter wrap through zero
    force dut.ts_cnt = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    release dut.ts_cnt;
    toggle(1'b1, 1, '0);
    wait_cycles(10);
    toggle(1'b1, 2, 64'd10);
    wait_cycles(10);
    toggle(1'b1, 2, 64'd10);
    wait_cycles(20);
    check_eq("t6_wrapped_low", 64'(last_ts < 64'h40), 64'd1);
    check_eq("t6_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
